// File: rtl/mxint8_add_seq_if.sv
// ---------------------------------------------------------------------------
// mxint8_add_seq_if
//
// Stream bundle for the MXINT8 block adder. One input beat carries one
// element pair (plus the two block scales, meaningful on beat 0 only); one
// output beat carries one result element plus the block-constant result
// scale. busy and nan_flag are status outputs of the adder.
//
// Modports:
//   master - the side that feeds operand beats and consumes result beats
//   slave  - the block adder itself
// ---------------------------------------------------------------------------
interface mxint8_add_seq_if #(
    parameter int ELEM_W  = 8,
    parameter int SCALE_W = 8
);
    // input element-pair stream
    logic               in_valid;
    logic               in_ready;
    logic [SCALE_W-1:0] in_scale_a;
    logic [SCALE_W-1:0] in_scale_b;
    logic [ELEM_W-1:0]  in_elem_a;
    logic [ELEM_W-1:0]  in_elem_b;

    // result stream
    logic               out_valid;
    logic               out_ready;
    logic [SCALE_W-1:0] out_scale;
    logic [ELEM_W-1:0]  out_elem;
    logic               out_last;

    // status
    logic               busy;
    logic               nan_flag;

    modport master (
        output in_valid, in_scale_a, in_scale_b, in_elem_a, in_elem_b,
        output out_ready,
        input  in_ready,
        input  out_valid, out_scale, out_elem, out_last,
        input  busy, nan_flag
    );

    modport slave (
        input  in_valid, in_scale_a, in_scale_b, in_elem_a, in_elem_b,
        input  out_ready,
        output in_ready,
        output out_valid, out_scale, out_elem, out_last,
        output busy, nan_flag
    );
endinterface

// File: rtl/mxint8_add_seq.sv
// ---------------------------------------------------------------------------
// mxint8_add_seq
//
// Sequential adder for two MXINT8 blocks (BLOCK_SIZE two's-complement
// elements sharing one E8M0 scale each). Element pairs stream in one beat at
// a time; each pair is aligned to the larger of the two scales, summed and
// written to an internal buffer while the largest magnitude is tracked. A
// one-cycle normalisation step then decides whether the result scale must
// grow by one, and the buffered sums are streamed out as MXINT8 elements
// saturated to [-127, 127].
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mxint8_add_seq_if.slave:
//              in_valid/in_ready, in_scale_a/b, in_elem_a/b  (operand beats)
//              out_valid/out_ready, out_scale, out_elem, out_last (results)
//              busy (not IDLE), nan_flag (result block is NaN)
// ---------------------------------------------------------------------------
module mxint8_add_seq #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_W     = 8,
    parameter int SCALE_W    = 8,
    parameter int ACC_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mxint8_add_seq_if.slave      bus
);
    // Elements are widened with FRAC_W fraction bits before alignment so that
    // right shifts keep some precision.
    localparam int FRAC_W = 8;
    localparam int CNT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int SH_W   = $clog2(ACC_W);
    localparam int SHMAX  = ACC_W - 1;

    localparam logic [SCALE_W-1:0] SCALE_NAN   = '1;
    // Largest finite E8M0 scale (254 for 8 bits).
    localparam logic [SCALE_W:0]   SCALE_LIMIT = {1'b0, {(SCALE_W-1){1'b1}}, 1'b0};
    // Any magnitude at or above one full-scale element needs an extra bit of
    // scale to fit back into ELEM_W bits.
    localparam logic [ACC_W-1:0]   NORM_THRESH = ACC_W'(1) << (ELEM_W - 1 + FRAC_W);
    localparam logic signed [ACC_W-1:0] ELEM_MAX_ACC = ACC_W'((1 << (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ELEM_MIN_ACC = -ELEM_MAX_ACC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        NORM  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   beat_reg;
    logic [CNT_W-1:0]   rd_idx_reg;
    logic [SCALE_W-1:0] smax_reg;
    logic [SCALE_W-1:0] da_reg;
    logic [SCALE_W-1:0] db_reg;
    logic               scale_nan_reg;
    logic [ACC_W-1:0]   max_abs_reg;
    logic               nshift_reg;
    logic [SCALE_W-1:0] out_scale_reg;
    logic [ELEM_W-1:0]  out_elem_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               nan_flag_reg;

    logic in_ready_int;
    logic in_hs;
    logic out_hs;
    logic emit_load;
    logic rd_en;

    // ------------------------------------------------------------------
    // Handshakes. in_ready is gated by rst_n so it is low for the whole
    // reset interval even though the state register already reads IDLE.
    // ------------------------------------------------------------------
    assign in_ready_int = rst_n && ((state_reg == IDLE) || (state_reg == ACCUM));
    assign in_hs        = bus.in_valid && in_ready_int;
    assign out_hs       = out_valid_reg && bus.out_ready;

    // ------------------------------------------------------------------
    // Scale alignment. On beat 0 the shifts come straight from the input
    // scales; later beats reuse the values latched on beat 0.
    // ------------------------------------------------------------------
    logic [SCALE_W-1:0] smax_in;
    logic [SCALE_W-1:0] da_in;
    logic [SCALE_W-1:0] db_in;

    assign smax_in = (bus.in_scale_a >= bus.in_scale_b) ? bus.in_scale_a : bus.in_scale_b;
    assign da_in   = smax_in - bus.in_scale_a;
    assign db_in   = smax_in - bus.in_scale_b;

    logic [ELEM_W-1:0]         elem_in   [2];
    logic [SCALE_W-1:0]        shift_sel [2];
    logic [SH_W-1:0]           shift_amt [2];
    logic signed [ACC_W-1:0]   widened   [2];
    logic signed [ACC_W-1:0]   aligned   [2];

    assign elem_in[0]   = bus.in_elem_a;
    assign elem_in[1]   = bus.in_elem_b;
    assign shift_sel[0] = (state_reg == IDLE) ? da_in : da_reg;
    assign shift_sel[1] = (state_reg == IDLE) ? db_in : db_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_align
            // Shifts beyond ACC_W-1 would only replicate the sign bit, so
            // they saturate at ACC_W-1.
            assign shift_amt[gi] = (shift_sel[gi] > SCALE_W'(SHMAX)) ? SH_W'(SHMAX)
                                                                      : SH_W'(shift_sel[gi]);
            assign widened[gi]   = $signed({{(ACC_W-ELEM_W){elem_in[gi][ELEM_W-1]}}, elem_in[gi]})
                                   <<< FRAC_W;
            assign aligned[gi]   = widened[gi] >>> shift_amt[gi];
        end
    endgenerate

    logic signed [ACC_W-1:0] entry_new;
    logic [ACC_W-1:0]        abs_new;

    assign entry_new = aligned[0] + aligned[1];
    assign abs_new   = entry_new[ACC_W-1] ? ACC_W'(-entry_new) : ACC_W'(entry_new);

    // ------------------------------------------------------------------
    // Normalisation decision (evaluated in NORM).
    // ------------------------------------------------------------------
    logic             norm_shift;
    logic [SCALE_W:0] scale_sum;
    logic             norm_nan;

    assign norm_shift = (max_abs_reg >= NORM_THRESH);
    assign scale_sum  = {1'b0, smax_reg} + {{SCALE_W{1'b0}}, norm_shift};
    assign norm_nan   = scale_nan_reg || (scale_sum > SCALE_LIMIT);

    // ------------------------------------------------------------------
    // Sum buffer: inferred RAM with a registered read port. Only written
    // in IDLE/ACCUM and only read in NORM/EMIT, so one port suffices.
    // rd_data always holds the sum for the beat *after* the one currently
    // presented, so the output register can advance on every handshake.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] entry_mem [BLOCK_SIZE];
    logic signed [ACC_W-1:0] rd_data;
    logic [CNT_W-1:0]        wr_addr;
    logic [CNT_W-1:0]        rd_addr;

    assign wr_addr = (state_reg == IDLE) ? '0 : count_reg;
    assign rd_addr = (state_reg == NORM) ? '0 : rd_idx_reg;

    // The last output load prefetches one slot past the block; that value
    // is never presented.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            entry_mem[wr_addr] <= entry_new;
        end
        if (rd_en) begin
            rd_data <= entry_mem[rd_addr];
        end
    end

    // Output element: floor shift back to ELEM_W scale, then saturate.
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clamped;
    logic [ELEM_W-1:0]       elem_next;

    assign shifted = rd_data >>> (nshift_reg ? (FRAC_W + 1) : FRAC_W);

    always_comb begin
        clamped = shifted;
        if (shifted > ELEM_MAX_ACC) begin
            clamped = ELEM_MAX_ACC;
        end else if (shifted < ELEM_MIN_ACC) begin
            clamped = ELEM_MIN_ACC;
        end
    end

    assign elem_next = clamped[ELEM_W-1:0];

    // Beat index of the element loaded next: 0 on the first load of a block,
    // otherwise one past the element being replaced.
    logic [CNT_W-1:0] beat_show;
    assign beat_show = out_valid_reg ? (beat_reg + CNT_W'(1)) : '0;

    // ------------------------------------------------------------------
    // FSM next state and control strobes.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        emit_load  = 1'b0;
        rd_en      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (in_hs) begin
                    state_next = (BLOCK_SIZE == 1) ? NORM : ACCUM;
                end
            end
            ACCUM: begin
                if (in_hs && (count_reg == CNT_W'(BLOCK_SIZE - 1))) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                rd_en      = 1'b1;
                state_next = EMIT;
            end
            EMIT: begin
                // First EMIT cycle primes the output register; afterwards
                // a new element is loaded on every non-final handshake.
                emit_load = !out_valid_reg || (out_hs && !out_last_reg);
                rd_en     = emit_load;
                if (out_hs && out_last_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            beat_reg      <= '0;
            rd_idx_reg    <= '0;
            smax_reg      <= '0;
            da_reg        <= '0;
            db_reg        <= '0;
            scale_nan_reg <= 1'b0;
            max_abs_reg   <= '0;
            nshift_reg    <= 1'b0;
            out_scale_reg <= '0;
            out_elem_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            nan_flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (in_hs) begin
                if (state_reg == IDLE) begin
                    smax_reg      <= smax_in;
                    da_reg        <= da_in;
                    db_reg        <= db_in;
                    scale_nan_reg <= (bus.in_scale_a == SCALE_NAN) ||
                                     (bus.in_scale_b == SCALE_NAN);
                    max_abs_reg   <= abs_new;
                    count_reg     <= CNT_W'(1);
                end else begin
                    if (abs_new > max_abs_reg) begin
                        max_abs_reg <= abs_new;
                    end
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            if (state_reg == NORM) begin
                nshift_reg    <= norm_shift;
                out_scale_reg <= norm_nan ? SCALE_NAN : scale_sum[SCALE_W-1:0];
                nan_flag_reg  <= norm_nan;
                rd_idx_reg    <= CNT_W'(1);
                beat_reg      <= '0;
            end

            if (emit_load) begin
                out_elem_reg  <= elem_next;
                out_valid_reg <= 1'b1;
                out_last_reg  <= (beat_show == CNT_W'(BLOCK_SIZE - 1));
                beat_reg      <= beat_show;
                rd_idx_reg    <= rd_idx_reg + CNT_W'(1);
            end else if (out_hs) begin
                // Only reachable on the out_last handshake.
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_scale = out_scale_reg;
    assign bus.out_elem  = out_elem_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.nan_flag  = nan_flag_reg;

endmodule

// File: doc/mxint8_add_seq.md
MXINT8_ADD_SEQ -- requirements
Module: mxint8_add_seq

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32: elements per MX block.
REQ-002 SHALL have parameter ELEM_W, default 8: MXINT8 element width, two's complement.
REQ-003 SHALL have parameter SCALE_W, default 8: E8M0 shared scale width, bias 127; 8'hFF is NaN.
REQ-004 SHALL have parameter ACC_W, default 24: aligned-sum buffer width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: input element-pair beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts an input beat.
REQ-009 SHALL have ports in_scale_a and in_scale_b, input, SCALE_W bits each: block scales, sampled on beat 0 only.
REQ-010 SHALL have ports in_elem_a and in_elem_b, input, ELEM_W bits each: element pair for the current beat.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts a result beat.
REQ-013 SHALL have port out_scale, output, SCALE_W bits: result block scale, constant over all beats of a block.
REQ-014 SHALL have port out_elem, output, ELEM_W bits: result element.
REQ-015 SHALL have port out_last, output, 1 bit: high on beat BLOCK_SIZE-1.
REQ-016 SHALL have ports busy and nan_flag, output, 1 bit each: busy is high in any state other than IDLE; nan_flag marks a NaN result block.

Function
REQ-017 SHALL implement FSM IDLE -> ACCUM -> NORM -> EMIT -> IDLE.
REQ-018 SHALL define a handshake as valid&&ready at a rising edge; data SHALL be held by the source until that edge.
REQ-019 SHALL assert in_ready only in IDLE and ACCUM.
REQ-020 On the IDLE handshake (beat 0), SHALL latch smax=max(sa,sb), da=smax-sa, db=smax-sb, clear max_abs, write entry 0, and enter ACCUM with count=1.
REQ-021 SHALL compute each entry in ACC_W bits as (sext(a)<<<8)>>>min(da,23) + (sext(b)<<<8)>>>min(db,23), using arithmetic shifts.
REQ-022 SHALL update max_abs=max(max_abs,|entry|) on every write.
REQ-023 SHALL write entry[count] on each ACCUM handshake, and SHALL move to NORM on the handshake at count=BLOCK_SIZE-1.
REQ-024 In NORM (1 cycle), SHALL set nshift=1 if max_abs>=32768, else 0.
REQ-025 In NORM, SHALL set out_scale to 8'hFF with nan_flag=1 if sa or sb is 8'hFF, or if smax+nshift>254; otherwise out_scale=smax+nshift with nan_flag=0.
REQ-026 In EMIT, out_elem SHALL be entry>>>(8+nshift) (floor), clamped to [-127,127].
REQ-027 SHALL set out_valid first at the second rising edge after the final input handshake.
REQ-028 In EMIT, SHALL advance the beat index on each output handshake, and SHALL hold out_elem/out_last stable while out_ready is low.
REQ-029 SHALL return to IDLE on the out_last handshake, and SHALL allow in_ready high in the following cycle.
REQ-030 SHALL ignore in_valid outside IDLE/ACCUM; no input beat is lost or double-counted.

Reset
REQ-031 While rst_n=0, SHALL force state=IDLE, count=0, beat index=0, max_abs=0, in_ready=0, out_valid=0, out_scale=0, out_elem=0, out_last=0, busy=0, nan_flag=0.
REQ-032 SHALL discard any partial block on reset assertion in any state; buffer contents need not be cleared.
REQ-033 SHALL raise in_ready in the first cycle after rst_n deasserts.

Verification
REQ-034 Equal scales: sa=sb=127, all a=0x10, b=0x20 -> all out_elem=0x30, out_scale=127, nan_flag=0, out_last on beat 31 only.
REQ-035 Scale alignment: sa=130, sb=127, all a=b=64 -> entry 18432, out_elem=72, out_scale=130.
REQ-036 Normalization and saturation: sa=sb=127, a=b=100 -> out_elem=100, out_scale=128; a=b=-128 (0x80) -> out_elem=0x81 (-127), out_scale=128.
REQ-037 NaN: sa=sb=254 with a=b=100 -> out_scale=8'hFF, nan_flag=1; sa=8'hFF with any data -> out_scale=8'hFF.
REQ-038 Flow control: random in_valid gaps plus out_ready low for 5 cycles on beat 10 -> beat 10 is held stable, all 32 beats delivered in order, and in_ready=0 throughout NORM/EMIT.
REQ-039 Reset mid-ACCUM at beat 15 -> all outputs take REQ-031 values; a following full block produces only correct results from the new block.
